hms_time_keeper: RTL

Time-of-day source for the six-digit display path. Counts hours, minutes and seconds from a free-running system clock. Two debounced pushbuttons let the user stop the time and set each field. Outputs feed the digit-split and decode stages, plus a per-digit blank mask that blinks the field being edited.

---
 rtl/hms_time_keeper.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/hms_time_keeper.sv
// ---------------------------------------------------------------------------
// hms_time_keeper : HH:MM:SS time-of-day counter with two-button set/blink UI
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hms_btn_debounce #(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_prev_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  // Rising edge of the accepted level only; release is silent.
  assign press_o = level_q & ~level_prev_q;

endmodule

module hms_time_keeper #(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYC    = 1000000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic [5:0] o_six_blank,
  output logic       o_tick
);

  localparam logic [1:0] MODE_CLOCK    = 2'd0;
  localparam logic [1:0] MODE_SET_SEC  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_HOUR = 2'd3;

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  logic          mode_pulse;
  logic          inc_pulse;

  logic [1:0]    mode_q;
  logic [1:0]    mode_d;
  logic [5:0]    sec_q;
  logic [5:0]    sec_d;
  logic [5:0]    min_q;
  logic [5:0]    min_d;
  logic [4:0]    hour_q;
  logic [4:0]    hour_d;
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick_q;
  logic          tick_now;
  logic [BW-1:0] blink_cnt_q;
  logic [BW-1:0] blink_cnt_d;
  logic          phase_q;
  logic          phase_d;
  logic [5:0]    blank_q;
  logic [5:0]    blank_d;
  logic          inc_ok;

  hms_btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (i_btn_mode),
    .press_o (mode_pulse)
  );

  hms_btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (i_btn_inc),
    .press_o (inc_pulse)
  );

  // A simultaneous mode press takes precedence and swallows the increment.
  assign inc_ok   = inc_pulse & ~mode_pulse & (mode_q != MODE_CLOCK);
  assign tick_now = (mode_q == MODE_CLOCK) && (tick_cnt_q == TICK_MAX);

  always_comb begin
    tick_cnt_d = '0;
    if ((mode_q == MODE_CLOCK) && !tick_now) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_pulse) begin
      case (mode_q)
        MODE_CLOCK:   mode_d = MODE_SET_SEC;
        MODE_SET_SEC: mode_d = MODE_SET_MIN;
        MODE_SET_MIN: mode_d = MODE_SET_HOUR;
        default:      mode_d = MODE_CLOCK;
      endcase
    end
  end

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (tick_now) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    if (inc_ok) begin
      case (mode_q)
        MODE_SET_SEC:  sec_d  = (sec_q == 6'd59)  ? 6'd0 : sec_q + 6'd1;
        MODE_SET_MIN:  min_d  = (min_q == 6'd59)  ? 6'd0 : min_q + 6'd1;
        MODE_SET_HOUR: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        default:       ;
      endcase
    end
  end

  // Restarting the blink on each edit keeps the new value visible at once.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (mode_pulse || inc_ok) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_comb begin
    blank_d = 6'b000000;
    case (mode_d)
      MODE_SET_SEC:  blank_d = {4'b0000, {2{phase_d}}};
      MODE_SET_MIN:  blank_d = {2'b00, {2{phase_d}}, 2'b00};
      MODE_SET_HOUR: blank_d = {{2{phase_d}}, 4'b0000};
      default:       blank_d = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_CLOCK;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= 6'b000000;
    end else begin
      mode_q      <= mode_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_now;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
    end
  end

  assign o_sec       = sec_q;
  assign o_min       = min_q;
  assign o_hour      = hour_q;
  assign o_mode      = mode_q;
  assign o_six_blank = blank_q;
  assign o_tick      = tick_q;

endmodule

`default_nettype wire
